// File: rtl/cla_seq_pkg.sv
// Shared types for the multi-word CLA sequencer.
// State encoding and index-width helper.
package cla_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// Combinational carry-look-ahead adder, WIDTH bits.
// Each carry is a flat OR of generate/propagate products.
module carry_look_ahead #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   cy;
  logic             acc;
  logic             pp;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    cy  = '0;
    acc = 1'b0;
    pp  = 1'b1;
    cy[0] = y;
    for (int i = 0; i < WIDTH; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      cy[i+1] = acc | (pp & y);
    end
  end

  assign s = p ^ cy[WIDTH-1:0];
  assign c = cy[WIDTH];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Multi-precision adder: one shared CLA time-shared over
// WORDS operand words, least-significant word first.
module cla_multiword_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cin,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] sum;
  logic             carry_reg;
  logic             c_next;
  logic             accept;

  carry_look_ahead #(
    .WIDTH(WIDTH)
  ) u_cla (
    .a(a_reg),
    .b(in_data),
    .y(carry_reg),
    .s(sum),
    .c(c_next)
  );

  // B is only taken when the output slot is free or draining
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      GET_A:   in_ready = 1'b1;
      GET_B:   in_ready = !out_valid || out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            carry_reg <= cin;
            idx       <= '0;
            state     <= GET_A;
          end
        end
        GET_A: begin
          if (in_valid) begin
            a_reg <= in_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (accept) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            carry_reg <= c_next;
            if (idx == LAST) begin
              state <= DRAIN;
            end else begin
              idx   <= idx + IW'(1);
              state <= GET_A;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            carry_out <= carry_reg;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
